// File: rtl/icmp_responder.sv
// ICMP engine: answers echo requests, drops malformed or oversized ones and
// flags destination-unreachable messages that quote a chosen UDP source port.
`timescale 1ns/1ps
module icmp_responder #(
    parameter int          MAX_PAYLOAD  = 512,
    parameter logic [15:0] UNREACH_PORT = 16'd1024,
    parameter int          UNREACH_EN   = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx_enable,
    input  logic [7:0]  rx_data,
    input  logic [47:0] remote_mac,
    input  logic [31:0] remote_ip,
    input  logic        tx_enable,
    output logic        tx_request,
    output logic        tx_active,
    output logic [7:0]  tx_data,
    output logic [15:0] length,
    output logic [47:0] destination_mac,
    output logic [31:0] destination_ip,
    output logic        dst_unreachable,
    output logic [15:0] echo_count,
    output logic [15:0] drop_count
);
    // IDLE wait for type | HEADER code+checksum | PAYLOAD buffer+sum | CHECK verify
    // TXREQ wait grant   | TX emit reply        | DISCARD drain rx   | UNREACH port match

    localparam int          AW      = $clog2(MAX_PAYLOAD);
    localparam logic [AW:0] PTR_MAX = (AW + 1)'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        IDLE, HEADER, PAYLOAD, CHECK, TXREQ, TX, DISCARD, UNREACH
    } state_t;

    state_t        state;
    logic [AW:0]   wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   sum;
    logic [15:0]   rx_cks;
    logic [15:0]   cks;
    logic [15:0]   tx_idx;
    logic [4:0]    byte_idx;
    logic          rx_enable_d;
    logic [7:0]    mem [MAX_PAYLOAD];
    logic [7:0]    ram_q;
    logic          ram_we;
    logic [15:0]   chk_fold;

    function automatic logic [15:0] fold(input logic [31:0] v);
        logic [16:0] a;
        logic [15:0] b;
        a = {1'b0, v[15:0]} + {1'b0, v[31:16]};
        b = a[15:0] + {15'h0, a[16]};
        return b;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign ram_we   = (state == PAYLOAD) && rx_enable && (wr_ptr != PTR_MAX);
    assign chk_fold = fold(sum + 32'h0000_0800 + {16'h0, rx_cks});

    always_ff @(posedge clock) begin
        if (ram_we)
            mem[wr_ptr[AW-1:0]] <= rx_data;
        ram_q <= mem[rd_ptr];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            sum             <= '0;
            rx_cks          <= '0;
            cks             <= '0;
            tx_idx          <= '0;
            byte_idx        <= '0;
            rx_enable_d     <= 1'b0;
            tx_request      <= 1'b0;
            tx_active       <= 1'b0;
            tx_data         <= '0;
            length          <= '0;
            destination_mac <= '0;
            destination_ip  <= '0;
            dst_unreachable <= 1'b0;
            echo_count      <= '0;
            drop_count      <= '0;
        end else begin
            rx_enable_d     <= rx_enable;
            dst_unreachable <= 1'b0;
            case (state)
                IDLE: begin
                    // only a fresh rx_enable rise starts a message, so the tail
                    // of a packet that arrived while busy is never parsed
                    if (rx_enable && !rx_enable_d) begin
                        destination_mac <= remote_mac;
                        destination_ip  <= remote_ip;
                        sum             <= '0;
                        wr_ptr          <= '0;
                        byte_idx        <= 5'd1;
                        if (rx_data == 8'h08)
                            state <= HEADER;
                        else if (rx_data == 8'h03 && UNREACH_EN != 0)
                            state <= UNREACH;
                        else
                            state <= DISCARD;
                    end
                end
                HEADER: begin
                    if (!rx_enable) begin
                        state      <= IDLE;
                        drop_count <= sat_inc(drop_count);
                    end else begin
                        byte_idx <= byte_idx + 5'd1;
                        case (byte_idx)
                            5'd1: begin
                                if (rx_data != 8'h00) begin
                                    state      <= DISCARD;
                                    drop_count <= sat_inc(drop_count);
                                end
                            end
                            5'd2:    rx_cks[15:8] <= rx_data;
                            default: begin
                                rx_cks[7:0] <= rx_data;
                                state       <= PAYLOAD;
                            end
                        endcase
                    end
                end
                PAYLOAD: begin
                    if (!rx_enable) begin
                        state <= CHECK;
                    end else if (wr_ptr == PTR_MAX) begin
                        state      <= DISCARD;
                        drop_count <= sat_inc(drop_count);
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                        sum    <= sum + (wr_ptr[0] ? {24'h0, rx_data}
                                                   : {16'h0, rx_data, 8'h00});
                    end
                end
                CHECK: begin
                    if (wr_ptr < (AW + 1)'(4) || chk_fold != 16'hFFFF) begin
                        state      <= IDLE;
                        drop_count <= sat_inc(drop_count);
                    end else begin
                        length     <= 16'(wr_ptr) + 16'd4;
                        cks        <= ~fold(sum);
                        tx_request <= 1'b1;
                        state      <= TXREQ;
                    end
                end
                TXREQ: begin
                    if (tx_enable) begin
                        tx_request <= 1'b0;
                        tx_idx     <= '0;
                        rd_ptr     <= '0;
                        state      <= TX;
                    end
                end
                TX: begin
                    if (tx_idx < length) begin
                        tx_active <= 1'b1;
                        tx_idx    <= tx_idx + 16'd1;
                        // RAM read runs one byte ahead of the output register
                        if (tx_idx >= 16'd3)
                            rd_ptr <= rd_ptr + 1'b1;
                        case (tx_idx)
                            16'd0, 16'd1: tx_data <= 8'h00;
                            16'd2:        tx_data <= cks[15:8];
                            16'd3:        tx_data <= cks[7:0];
                            default:      tx_data <= ram_q;
                        endcase
                    end else begin
                        tx_active  <= 1'b0;
                        tx_data    <= 8'h00;
                        echo_count <= sat_inc(echo_count);
                        state      <= IDLE;
                    end
                end
                DISCARD: begin
                    if (!rx_enable)
                        state <= IDLE;
                end
                UNREACH: begin
                    if (!rx_enable) begin
                        state <= IDLE;
                    end else begin
                        byte_idx <= byte_idx + 5'd1;
                        if (byte_idx == 5'd28 && rx_data != UNREACH_PORT[15:8]) begin
                            state <= DISCARD;
                        end else if (byte_idx == 5'd29) begin
                            dst_unreachable <= (rx_data == UNREACH_PORT[7:0]);
                            state           <= DISCARD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if ((state == TXREQ || state == TX) && rx_enable && !rx_enable_d)
                drop_count <= sat_inc(drop_count);
        end
    end
endmodule

// File: tb/tb_icmp_responder.sv
// Bench for icmp_responder: vector table, corner-case sequences and random
// packets checked against a byte-level ICMP reference model.
`timescale 1ns/1ps
module tb_icmp_responder;
    localparam int          MAXP  = 64;
    localparam logic [15:0] UPORT = 16'd1024;

    typedef struct {
        string      name;
        logic [7:0] code;
        int         plen;
        bit         spec_ex;
        int         flip;
        bit         exp_reply;
        int         exp_len;
        int         exp_drop;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_enable = 1'b0;
    logic        sel2 = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [47:0] remote_mac = '0;
    logic [31:0] remote_ip = '0;
    logic        tx_enable = 1'b0;
    logic        rx1, rx2;

    logic        tx_request, tx_active, dst_unreachable;
    logic [7:0]  tx_data;
    logic [15:0] length, echo_count, drop_count;
    logic [47:0] destination_mac;
    logic [31:0] destination_ip;

    logic        d2_req, d2_act, d2_unr;
    logic [7:0]  d2_data;
    logic [15:0] d2_len, d2_echo, d2_drop;
    logic [47:0] d2_mac;
    logic [31:0] d2_ip;

    assign rx1 = rx_enable & ~sel2;
    assign rx2 = rx_enable & sel2;

    icmp_responder #(.MAX_PAYLOAD(MAXP), .UNREACH_PORT(UPORT), .UNREACH_EN(1)) dut (
        .clock(clock), .reset_n(reset_n), .rx_enable(rx1), .rx_data(rx_data),
        .remote_mac(remote_mac), .remote_ip(remote_ip), .tx_enable(tx_enable),
        .tx_request(tx_request), .tx_active(tx_active), .tx_data(tx_data),
        .length(length), .destination_mac(destination_mac),
        .destination_ip(destination_ip), .dst_unreachable(dst_unreachable),
        .echo_count(echo_count), .drop_count(drop_count));

    icmp_responder #(.MAX_PAYLOAD(MAXP), .UNREACH_PORT(UPORT), .UNREACH_EN(0)) dut2 (
        .clock(clock), .reset_n(reset_n), .rx_enable(rx2), .rx_data(rx_data),
        .remote_mac(remote_mac), .remote_ip(remote_ip), .tx_enable(1'b0),
        .tx_request(d2_req), .tx_active(d2_act), .tx_data(d2_data),
        .length(d2_len), .destination_mac(d2_mac),
        .destination_ip(d2_ip), .dst_unreachable(d2_unr),
        .echo_count(d2_echo), .drop_count(d2_drop));

    always #5 clock = ~clock;

    int checks = 0;
    int fails = 0;
    int unr_cnt = 0;
    int unr2_cnt = 0;
    logic [7:0]  pkt[$];
    logic [7:0]  exp_q[$];
    logic [47:0] exp_mac;
    logic [31:0] exp_ip;

    always @(negedge clock) begin
        if (dst_unreachable) unr_cnt++;
        if (d2_unr) unr2_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ones-complement sum of a byte stream taken as big-endian 16-bit words
    function automatic logic [15:0] ocsum(input logic [7:0] b[$]);
        int unsigned s;
        int unsigned w;
        s = 0;
        for (int i = 0; i < b.size(); i++) begin
            w = b[i];
            if (i % 2 == 0) w = w << 8;
            s += w;
        end
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    task automatic build_echo(input logic [7:0] code, input int plen, input bit spec_ex, input int flip);
        logic [15:0] c;
        logic [7:0]  ex[8];
        ex = '{8'h12, 8'h34, 8'h00, 8'h01, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
        pkt = {8'h08, code, 8'h00, 8'h00};
        for (int i = 0; i < plen; i++)
            pkt.push_back(spec_ex ? ex[i % 8] : 8'($urandom_range(0, 255)));
        c = ~ocsum(pkt);
        pkt[2] = c[15:8];
        pkt[3] = c[7:0];
        if (flip >= 0)
            pkt[2 + flip / 8] = pkt[2 + flip / 8] ^ (8'h01 << (flip % 8));
    endtask

    task automatic build_unreach(input int len, input logic [7:0] b28, input logic [7:0] b29);
        pkt = {8'h03, 8'h03};
        for (int i = 2; i < len; i++) pkt.push_back(8'($urandom_range(0, 255)));
        if (len >= 30) begin
            pkt[28] = b28;
            pkt[29] = b29;
        end
    endtask

    task automatic model(output bit reply, output int drop, output int pulse);
        logic [7:0]  payload[$];
        logic [15:0] c;
        reply = 0; drop = 0; pulse = 0;
        exp_q = {};
        if (pkt[0] == 8'h08) begin
            if (pkt.size() >= 8 && pkt[1] == 8'h00 && pkt.size() - 4 <= MAXP
                && ocsum(pkt) == 16'hFFFF) begin
                reply   = 1;
                payload = pkt[4:$];
                c       = ~ocsum(payload);
                exp_q   = {8'h00, 8'h00, c[15:8], c[7:0]};
                exp_q   = {exp_q, payload};
            end else begin
                drop = 1;
            end
        end else if (pkt[0] == 8'h03 && pkt.size() >= 30
                     && pkt[28] == UPORT[15:8] && pkt[29] == UPORT[7:0]) begin
            pulse = 1;
        end
    endtask

    task automatic send_pkt();
        remote_mac = {16'($urandom), 32'($urandom)};
        remote_ip  = 32'($urandom);
        for (int i = 0; i < pkt.size(); i++) begin
            @(posedge clock); #1;
            rx_enable = 1'b1;
            rx_data   = pkt[i];
        end
        @(posedge clock); #1;
        rx_enable = 1'b0;
        rx_data   = 8'h00;
    endtask

    task automatic wait_req(output int lat);
        bit got;
        got = 0; lat = 0;
        while (!got && lat < 8) begin
            @(posedge clock); #1;
            lat++;
            if (tx_request) got = 1;
        end
        if (!got) lat = 99;
    endtask

    task automatic run_reply(input string tag, input int exp_len);
        int         lat;
        logic [7:0] act_q[$];
        wait_req(lat);
        check({tag, "_req_latency"}, 64'(lat), 64'd2);
        if (lat == 2) begin
            check({tag, "_length"}, length, 64'(exp_len));
            check({tag, "_dst_mac"}, destination_mac, exp_mac);
            check({tag, "_dst_ip"}, destination_ip, exp_ip);
            tx_enable = 1'b1;
            @(posedge clock); #1;
            tx_enable = 1'b0;
            check({tag, "_req_fall"}, {tx_request, tx_active}, 2'b00);
            for (int k = 0; k < exp_len; k++) begin
                @(posedge clock); #1;
                check({tag, "_tx_active"}, tx_active, 1'b1);
                check({tag, "_tx_byte"}, tx_data, (k < exp_q.size()) ? exp_q[k] : 8'h00);
                act_q.push_back(tx_data);
            end
            @(posedge clock); #1;
            check({tag, "_active_fall"}, tx_active, 1'b0);
            check({tag, "_reply_cks"}, ocsum(act_q), 16'hFFFF);
        end
    endtask

    task automatic quiet(input string tag);
        bit seen;
        seen = 0;
        repeat (5) begin
            @(posedge clock); #1;
            if (tx_request) seen = 1;
        end
        check({tag, "_no_request"}, seen, 1'b0);
    endtask

    task automatic process(input string tag, input bit exp_reply, input int exp_len,
                           input int exp_drop, input int exp_pulse);
        int d0, e0, u0;
        d0 = drop_count; e0 = echo_count; u0 = unr_cnt;
        send_pkt();
        exp_mac = remote_mac;
        exp_ip  = remote_ip;
        if (exp_reply) run_reply(tag, exp_len);
        else quiet(tag);
        repeat (2) @(posedge clock); #1;
        check({tag, "_drop"}, drop_count, 16'(d0 + exp_drop));
        check({tag, "_echo"}, echo_count, 16'(e0 + (exp_reply ? 1 : 0)));
        check({tag, "_pulses"}, 64'(unr_cnt - u0), 64'(exp_pulse));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tab[10];
        bit   r;
        int   dr, pu, lat, d0, e0, u0;

        tab[0] = '{"basic",   8'h00, 8,        1, -1, 1, 12,       0};
        tab[1] = '{"flip_hi", 8'h00, 8,        1,  5, 0, 0,        1};
        tab[2] = '{"odd5",    8'h00, 5,        0, -1, 1, 9,        0};
        tab[3] = '{"min4",    8'h00, 4,        0, -1, 1, 8,        0};
        tab[4] = '{"short3",  8'h00, 3,        0, -1, 0, 0,        1};
        tab[5] = '{"empty",   8'h00, 0,        0, -1, 0, 0,        1};
        tab[6] = '{"code1",   8'h01, 8,        0, -1, 0, 0,        1};
        tab[7] = '{"over",    8'h00, MAXP + 1, 0, -1, 0, 0,        1};
        tab[8] = '{"max",     8'h00, MAXP,     0, -1, 1, MAXP + 4, 0};
        tab[9] = '{"flip_lo", 8'h00, 12,       0, 11, 0, 0,        1};

        repeat (3) @(posedge clock); #1;
        check("rst_tx_request", tx_request, 1'b0);
        check("rst_tx_active", tx_active, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_length", length, 16'h0);
        check("rst_dst_mac", destination_mac, 48'h0);
        check("rst_dst_ip", destination_ip, 32'h0);
        check("rst_unreach", dst_unreachable, 1'b0);
        check("rst_echo", echo_count, 16'h0);
        check("rst_drop", drop_count, 16'h0);
        reset_n = 1'b1;
        repeat (2) @(posedge clock); #1;

        for (int i = 0; i < 10; i++) begin
            build_echo(tab[i].code, tab[i].plen, tab[i].spec_ex, tab[i].flip);
            model(r, dr, pu);
            process(tab[i].name, tab[i].exp_reply, tab[i].exp_len, tab[i].exp_drop, 0);
        end

        // unreachable match: pulse exactly in the cycle after byte 29
        build_unreach(30, 8'h04, 8'h00);
        u0 = unr_cnt;
        send_pkt();
        check("unr_pulse_on", dst_unreachable, 1'b1);
        @(posedge clock); #1;
        check("unr_pulse_off", dst_unreachable, 1'b0);
        repeat (2) @(posedge clock); #1;
        check("unr_pulse_count", 64'(unr_cnt - u0), 64'd1);

        build_unreach(30, 8'h04, 8'h01);
        process("unr_mismatch", 0, 0, 0, 0);
        build_unreach(40, 8'h04, 8'h00);
        process("unr_long", 0, 0, 0, 1);

        sel2 = 1'b1;
        u0 = unr2_cnt;
        d0 = d2_drop;
        build_unreach(30, 8'h04, 8'h00);
        send_pkt();
        repeat (3) @(posedge clock); #1;
        check("unr_disabled_pulses", 64'(unr2_cnt - u0), 64'd0);
        check("unr_disabled_drop", d2_drop, 16'(d0));
        sel2 = 1'b0;
        @(posedge clock); #1;

        // second request during the reply is dropped; the reply stays intact
        build_echo(8'h00, 8, 0, -1);
        model(r, dr, pu);
        d0 = drop_count; e0 = echo_count;
        send_pkt();
        exp_mac = remote_mac;
        exp_ip  = remote_ip;
        fork
            run_reply("busy", 12);
            begin
                repeat (6) @(posedge clock);
                build_echo(8'h00, 8, 0, -1);
                send_pkt();
            end
        join
        repeat (3) @(posedge clock); #1;
        check("busy_drop", drop_count, 16'(d0 + 1));
        check("busy_echo", echo_count, 16'(e0 + 1));

        // reset while byte 6 of a reply is on the wire
        build_echo(8'h00, 12, 0, -1);
        model(r, dr, pu);
        send_pkt();
        wait_req(lat);
        check("rst_tx_req_latency", 64'(lat), 64'd2);
        tx_enable = 1'b1;
        @(posedge clock); #1;
        tx_enable = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            @(posedge clock); #1;
            check("rst_tx_byte", tx_data, exp_q[k]);
        end
        reset_n = 1'b0;
        #1;
        check("mid_rst_tx_active", tx_active, 1'b0);
        check("mid_rst_tx_data", tx_data, 8'h00);
        check("mid_rst_tx_request", tx_request, 1'b0);
        check("mid_rst_length", length, 16'h0);
        check("mid_rst_dst", {destination_mac, destination_ip}, 80'h0);
        check("mid_rst_counts", {echo_count, drop_count}, 32'h0);
        repeat (2) @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        build_echo(8'h00, 6, 0, -1);
        model(r, dr, pu);
        process("post_rst", 1, 10, 0, 0);
        check("post_rst_echo_total", echo_count, 16'd1);

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind <= 5)
                build_echo(8'h00, $urandom_range(0, MAXP + 2), 0,
                           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1);
            else if (kind == 9)
                build_echo(8'($urandom_range(1, 255)), $urandom_range(0, 12), 0, -1);
            else if (kind <= 7)
                build_unreach($urandom_range(1, 40), ($urandom_range(0, 1) == 1) ? 8'h04 : 8'h05,
                              ($urandom_range(0, 2) != 0) ? 8'h00 : 8'h01);
            else begin
                pkt = {8'h11};
                repeat ($urandom_range(0, 20)) pkt.push_back(8'($urandom_range(0, 255)));
            end
            model(r, dr, pu);
            process("rand", r, exp_q.size(), dr, pu);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
